// File: rtl/cnt_run_ctrl.sv
// cnt_run_ctrl: run-length enable controller for the counter_enbl datapath.
// Optional back-to-back repeat mode: define CNT_RUN_CTRL_AUTORELOAD_EN.
module cnt_run_ctrl #(
    parameter int N = 4
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         start,
    input  logic [N-1:0] limit,
    input  logic         pause,
    input  logic         stop,
    output logic         cnt_enable,
    output logic         cnt_clear,
    output logic         busy,
    output logic         done,
    output logic [N-1:0] run_cnt,
    output logic [2:0]   state
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_CLEAR = 3'd1,
        S_RUN   = 3'd2,
        S_PAUSE = 3'd3,
        S_DONE  = 3'd4
    } state_t;

    state_t       st_q;
    state_t       st_d;
    logic [N-1:0] lim_r;
    logic [N-1:0] cnt_q;
    logic         accept;
    logic         last;

    assign accept = (st_q == S_IDLE) && start && !stop;
    // lim_r is nonzero whenever RUN is reached, so lim_r-1 cannot underflow
    assign last   = (cnt_q == (lim_r - N'(1)));

    always_ff @(posedge clk) begin
        if (!reset) begin
            st_q  <= S_IDLE;
            lim_r <= '0;
            cnt_q <= '0;
        end else begin
            st_q <= st_d;
            if (accept) begin
                lim_r <= limit;
            end
            if (st_q == S_CLEAR) begin
                cnt_q <= '0;
            end else if (st_q == S_RUN) begin
                cnt_q <= cnt_q + N'(1);
            end
        end
    end

    always_comb begin
        st_d = S_IDLE;
        unique case (st_q)
            S_IDLE: begin
                st_d = accept ? S_CLEAR : S_IDLE;
            end
            S_CLEAR: begin
                if (stop) begin
                    st_d = S_IDLE;
                end else if (lim_r == '0) begin
                    st_d = S_DONE;
                end else begin
                    st_d = S_RUN;
                end
            end
            S_RUN: begin
                if (stop) begin
                    st_d = S_IDLE;
                end else if (last) begin
                    st_d = S_DONE;
                end else if (pause) begin
                    st_d = S_PAUSE;
                end else begin
                    st_d = S_RUN;
                end
            end
            S_PAUSE: begin
                if (stop) begin
                    st_d = S_IDLE;
                end else if (!pause) begin
                    st_d = S_RUN;
                end else begin
                    st_d = S_PAUSE;
                end
            end
            S_DONE: begin
`ifdef CNT_RUN_CTRL_AUTORELOAD_EN
                st_d = stop ? S_IDLE : S_CLEAR;
`else
                st_d = S_IDLE;
`endif
            end
            default: begin
                st_d = S_IDLE;
            end
        endcase
    end

    assign cnt_clear  = (st_q == S_CLEAR);
    assign cnt_enable = (st_q == S_RUN);
    assign done       = (st_q == S_DONE);
    assign busy       = (st_q == S_CLEAR) ||
                        (st_q == S_RUN) ||
                        (st_q == S_PAUSE);
    assign run_cnt    = cnt_q;
    assign state      = st_q;

endmodule

// File: tb/tb_cnt_run_ctrl.sv
// tb_cnt_run_ctrl: directed vector table plus hand sequences for cnt_run_ctrl.
// Autoreload vectors are included when CNT_RUN_CTRL_AUTORELOAD_EN is defined.
module tb_cnt_run_ctrl;

    localparam int N = 4;

    logic         clk = 1'b0;
    logic         reset = 1'b0;
    logic         start = 1'b0;
    logic         pause = 1'b0;
    logic         stop = 1'b0;
    logic [N-1:0] limit = '0;
    logic         cnt_enable;
    logic         cnt_clear;
    logic         busy;
    logic         done;
    logic [N-1:0] run_cnt;
    logic [2:0]   state;
    logic [N-1:0] ctr;

    cnt_run_ctrl #(.N(N)) dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .limit      (limit),
        .pause      (pause),
        .stop       (stop),
        .cnt_enable (cnt_enable),
        .cnt_clear  (cnt_clear),
        .busy       (busy),
        .done       (done),
        .run_cnt    (run_cnt),
        .state      (state)
    );

    always #5 clk = ~clk;

    // stand-in for counter_enbl, reset = ~reset | cnt_clear
    always_ff @(posedge clk) begin
        if (!reset || cnt_clear) begin
            ctr <= '0;
        end else if (cnt_enable) begin
            ctr <= ctr + 4'd1;
        end
    end

    typedef struct {
        logic       rst;
        logic       st;
        logic [3:0] lim;
        logic       pa;
        logic       sp;
        logic [2:0] es;
        logic [3:0] erc;
    } vec_t;

    vec_t tv[$];
    int   tests = 0;
    int   fails = 0;

    function automatic void add(logic r, logic s, logic [3:0] l,
                                logic p, logic k,
                                logic [2:0] es, logic [3:0] erc);
        vec_t v;
        v.rst = r;
        v.st  = s;
        v.lim = l;
        v.pa  = p;
        v.sp  = k;
        v.es  = es;
        v.erc = erc;
        tv.push_back(v);
    endfunction

    function automatic void check(string nm, int act, int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
        end
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    int         en_n;
    int         lat;
    int         got;
    int         ctr_at;
    logic [3:0] exp_fl;
    logic [3:0] act_fl;

    initial begin
        // reset held for two edges
        add(0, 0, 0, 0, 0, 0, 0);
        add(0, 0, 0, 0, 0, 0, 0);
        // basic run, limit 5
        add(1, 1, 5, 0, 0, 1, 0);
        for (int i = 0; i < 5; i++) add(1, 0, 5, 0, 0, 2, 4'(i));
        add(1, 0, 5, 0, 0, 4, 5);
        add(1, 0, 5, 0, 1, 0, 5);
        // pause for 3 cycles from 2nd RUN cycle, start in RUN ignored
        add(1, 1, 6, 0, 0, 1, 5);
        add(1, 0, 6, 0, 0, 2, 0);
        add(1, 0, 6, 0, 0, 2, 1);
        add(1, 0, 6, 1, 0, 3, 2);
        add(1, 0, 6, 1, 0, 3, 2);
        add(1, 0, 6, 1, 0, 3, 2);
        add(1, 0, 6, 0, 0, 2, 2);
        add(1, 1, 1, 0, 0, 2, 3);
        add(1, 0, 6, 0, 0, 2, 4);
        add(1, 0, 6, 0, 0, 2, 5);
        add(1, 0, 6, 0, 0, 4, 6);
        add(1, 0, 6, 0, 1, 0, 6);
        // stop in 4th RUN cycle; limit change after accept ignored
        add(1, 1, 10, 0, 0, 1, 6);
        add(1, 0, 2, 0, 0, 2, 0);
        add(1, 0, 2, 0, 0, 2, 1);
        add(1, 0, 2, 0, 0, 2, 2);
        add(1, 0, 2, 0, 0, 2, 3);
        add(1, 0, 2, 0, 1, 0, 4);
        add(1, 1, 3, 0, 1, 0, 4);
        add(1, 0, 3, 0, 0, 0, 4);
        // limit 0
        add(1, 1, 0, 0, 0, 1, 4);
        add(1, 0, 0, 0, 0, 4, 0);
        add(1, 0, 0, 0, 1, 0, 0);
        // limit 15, no wrap
        add(1, 1, 15, 0, 0, 1, 0);
        for (int i = 0; i < 15; i++) add(1, 0, 15, 0, 0, 2, 4'(i));
        add(1, 0, 15, 0, 0, 4, 15);
        add(1, 0, 15, 0, 1, 0, 15);
        // pause on last RUN cycle
        add(1, 1, 3, 0, 0, 1, 15);
        add(1, 0, 3, 0, 0, 2, 0);
        add(1, 0, 3, 0, 0, 2, 1);
        add(1, 0, 3, 0, 0, 2, 2);
        add(1, 0, 3, 1, 0, 4, 3);
        add(1, 0, 3, 1, 1, 0, 3);
        add(1, 0, 3, 1, 0, 0, 3);
        // reset during PAUSE of an 8-cycle run, then clean limit 3 run
        add(1, 1, 8, 0, 0, 1, 3);
        add(1, 0, 8, 0, 0, 2, 0);
        add(1, 0, 8, 0, 0, 2, 1);
        add(1, 0, 8, 1, 0, 3, 2);
        add(1, 0, 8, 1, 0, 3, 2);
        add(0, 1, 8, 1, 1, 0, 0);
        add(1, 1, 3, 0, 0, 1, 0);
        add(1, 0, 3, 0, 0, 2, 0);
        add(1, 0, 3, 0, 0, 2, 1);
        add(1, 0, 3, 0, 0, 2, 2);
        add(1, 0, 3, 0, 0, 4, 3);
        add(1, 0, 3, 0, 1, 0, 3);
`ifdef CNT_RUN_CTRL_AUTORELOAD_EN
        // repeating CLEAR, 3xRUN, DONE; stop in DONE ends it
        add(1, 1, 3, 0, 0, 1, 3);
        for (int r = 0; r < 3; r++) begin
            add(1, 0, 3, 0, 0, 2, 0);
            add(1, 0, 3, 0, 0, 2, 1);
            add(1, 0, 3, 0, 0, 2, 2);
            add(1, 0, 3, 0, 0, 4, 3);
            if (r < 2) add(1, 0, 3, 0, 0, 1, 3);
        end
        add(1, 0, 3, 0, 1, 0, 3);
`endif

        for (int i = 0; i < tv.size(); i++) begin
            reset = tv[i].rst;
            start = tv[i].st;
            limit = tv[i].lim;
            pause = tv[i].pa;
            stop  = tv[i].sp;
            step();
            exp_fl = {tv[i].es == 3'd1, tv[i].es == 3'd2,
                      tv[i].es == 3'd4,
                      tv[i].es inside {3'd1, 3'd2, 3'd3}};
            act_fl = {cnt_clear, cnt_enable, done, busy};
            tests++;
            if (state !== tv[i].es || run_cnt !== tv[i].erc ||
                act_fl !== exp_fl) begin
                fails++;
                $display("FAIL vec%0d: got st=%0d rc=%0d clr/en/dn/bsy=%b, expected st=%0d rc=%0d clr/en/dn/bsy=%b",
                         i, state, run_cnt, act_fl,
                         tv[i].es, tv[i].erc, exp_fl);
            end
        end

        // hand sequence: latency, enable count and counter value
        reset = 1'b1;
        pause = 1'b0;
        stop  = 1'b0;
        start = 1'b1;
        limit = 4'd5;
        step();
        start = 1'b0;
        en_n = 0;
        lat = 0;
        got = 0;
        ctr_at = 0;
        for (int k = 1; k <= 30 && got == 0; k++) begin
            step();
            if (cnt_enable) en_n++;
            if (done) begin
                got = 1;
                lat = k;
                ctr_at = int'(ctr);
            end
        end
        check("hand_done_seen", got, 1);
        check("hand_latency", lat, 6);
        check("hand_enables", en_n, 5);
        check("hand_counter", ctr_at, 5);
        check("hand_run_cnt", int'(run_cnt), 5);
        stop = 1'b1;
        step();
        stop = 1'b0;
        check("hand_idle", int'(state), 0);

`ifdef CNT_RUN_CTRL_AUTORELOAD_EN
        // done pulses over 15 cycles of repeating limit-3 runs
        start = 1'b1;
        limit = 4'd3;
        step();
        start = 1'b0;
        got = (done) ? 1 : 0;
        for (int k = 1; k < 15; k++) begin
            step();
            if (done) got++;
        end
        check("auto_done_count", got, 3);
        stop = 1'b1;
        step();
        stop = 1'b0;
        check("auto_stop_idle", int'(state), 0);
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
